// File: rtl/prog_fetch.sv
// Program fetch sequencer: IDLE/RUN/HALT control, program counter with
// LUT-based branch targets, and a saturating retired-instruction counter.
module prog_fetch #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_done_in,
    input  logic              i_jen,
    input  logic [7:0]        i_jptr,
    input  logic              i_branch_cond,
    input  logic              i_stall,
    input  logic              i_lut_we,
    input  logic [LUT_AW-1:0] i_lut_addr,
    input  logic [PC_W-1:0]   i_lut_data,
    output logic [PC_W-1:0]   o_prog_ctr,
    output logic              o_fetch,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_instr_cnt
);

    localparam int LUT_DEPTH = 1 << LUT_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fetch;
    logic             r_done;
    logic [PC_W-1:0]  r_lut [LUT_DEPTH];

    logic [1:0]        w_state_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [LUT_AW-1:0] w_jidx;
    logic              w_lut_wr;

    assign w_jidx   = i_jptr[LUT_AW-1:0];
    assign w_lut_wr = i_lut_we && (r_state != S_RUN);

    // Next-state, next-PC and retire-count selection
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = {PC_W{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                if (!i_stall) begin
                    // The halting instruction still retires; the counter never wraps
                    if (r_cnt == {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt;
                    end else begin
                        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (i_done_in) begin
                        w_state_nxt = S_HALT;
                    end else if (i_jen && i_branch_cond) begin
                        w_pc_nxt = r_lut[w_jidx];
                    end else begin
                        w_pc_nxt = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = {PC_W{1'b0}};
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control and datapath registers; status flags follow the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= {PC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_fetch <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fetch <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_HALT);
        end
    end

    // Jump-target table, writable only while no program is running
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= {PC_W{1'b0}};
            end
        end else if (w_lut_wr) begin
            r_lut[i_lut_addr] <= i_lut_data;
        end
    end

    assign o_prog_ctr  = r_pc;
    assign o_fetch     = r_fetch;
    assign o_done      = r_done;
    assign o_instr_cnt = r_cnt;

endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch: directed steps push expected outputs,
// a negedge monitor pops and compares against a 16-bit and a 4-bit counter build.
module tb_prog_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, done_in, jen, bc, stall, lut_we;
    logic [7:0] jptr;
    logic [5:0] lut_addr;
    logic [9:0] lut_data;

    logic [9:0]  pc_a, pc_b;
    logic        fetch_a, fetch_b, done_a, done_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0]  pc;
        logic [15:0] cnt;
        logic        f;
        logic        d;
        logic [7:0]  id;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] step_id = 8'd0;

    always #5 clk = ~clk;

    prog_fetch #(.PC_W(10), .LUT_AW(6), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_done_in(done_in),
        .i_jen(jen), .i_jptr(jptr), .i_branch_cond(bc), .i_stall(stall),
        .i_lut_we(lut_we), .i_lut_addr(lut_addr), .i_lut_data(lut_data),
        .o_prog_ctr(pc_a), .o_fetch(fetch_a), .o_done(done_a), .o_instr_cnt(cnt_a)
    );

    prog_fetch #(.PC_W(10), .LUT_AW(6), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_done_in(done_in),
        .i_jen(jen), .i_jptr(jptr), .i_branch_cond(bc), .i_stall(stall),
        .i_lut_we(lut_we), .i_lut_addr(lut_addr), .i_lut_data(lut_data),
        .o_prog_ctr(pc_b), .o_fetch(fetch_b), .o_done(done_b), .o_instr_cnt(cnt_b)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, id, act, exv);
        end
    endtask

    task automatic chk_all_zero(input int id);
        chk("rst_pc", id, {22'd0, pc_a}, 32'd0);
        chk("rst_cnt", id, {16'd0, cnt_a}, 32'd0);
        chk("rst_fetch", id, {31'd0, fetch_a}, 32'd0);
        chk("rst_done", id, {31'd0, done_a}, 32'd0);
        chk("rst_pc4", id, {22'd0, pc_b}, 32'd0);
        chk("rst_cnt4", id, {28'd0, cnt_b}, 32'd0);
        chk("rst_fetch4", id, {31'd0, fetch_b}, 32'd0);
        chk("rst_done4", id, {31'd0, done_b}, 32'd0);
    endtask

    // Monitor: registered outputs are stable at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] c4;
            e  = exp_q.pop_front();
            c4 = (e.cnt > 16'd15) ? 4'd15 : e.cnt[3:0];
            chk("pc", e.id, {22'd0, pc_a}, {22'd0, e.pc});
            chk("cnt", e.id, {16'd0, cnt_a}, {16'd0, e.cnt});
            chk("fetch", e.id, {31'd0, fetch_a}, {31'd0, e.f});
            chk("done", e.id, {31'd0, done_a}, {31'd0, e.d});
            chk("pc4", e.id, {22'd0, pc_b}, {22'd0, e.pc});
            chk("cnt4", e.id, {28'd0, cnt_b}, {28'd0, c4});
        end
    end

    task automatic step(input logic st, input logic dn, input logic jn, input logic [7:0] jp,
                        input logic b, input logic sl, input logic we, input logic [5:0] wa,
                        input logic [9:0] wd, input logic [9:0] epc, input logic [15:0] ecnt,
                        input logic ef, input logic ed);
        exp_t e;
        start = st; done_in = dn; jen = jn; jptr = jp; bc = b;
        stall = sl; lut_we = we; lut_addr = wa; lut_data = wd;
        @(posedge clk);
        step_id = step_id + 8'd1;
        e.pc = epc; e.cnt = ecnt; e.f = ef; e.d = ed; e.id = step_id;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic plain(input logic [9:0] epc, input logic [15:0] ecnt);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, epc, ecnt, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; done_in = 1'b0; jen = 1'b0; bc = 1'b0;
        stall = 1'b0; lut_we = 1'b0; jptr = 8'd0; lut_addr = 6'd0; lut_data = 10'd0;
        #3;
        chk_all_zero(0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE writes; second write shares its edge with Start
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd1, 10'h3FE, 10'h000, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd5, 10'h040, 10'h000, 16'd0, 1'b1, 1'b0);
        plain(10'h001, 16'd1);
        plain(10'h002, 16'd2);
        plain(10'h003, 16'd3);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h040, 16'd4, 1'b1, 1'b0);
        // Jptr upper bits ignored: 0x41 selects entry 1
        step(1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h3FE, 16'd5, 1'b1, 1'b0);
        plain(10'h3FF, 16'd6);
        plain(10'h000, 16'd7);
        step(1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 6'd0, 10'd0, 10'h000, 16'd7, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd5, 10'h123, 10'h001, 16'd8, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h001, 16'd9, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 6'd2, 10'h2AA, 10'h001, 16'd9, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'h000, 16'd0, 1'b1, 1'b0);
        plain(10'h001, 16'd1);
        plain(10'h002, 16'd2);
        plain(10'h003, 16'd3);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'h004, 16'd4, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h040, 16'd5, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h2AA, 16'd6, 1'b1, 1'b0);
        // Run on to 20 retired; Start mid-run must be ignored
        for (int i = 1; i <= 14; i++) begin
            step((i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0,
                 10'h2AA + 10'(i), 16'd6 + 16'(i), 1'b1, 1'b0);
        end

        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero(100);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'h000, 16'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h000, 16'd1, 1'b1, 1'b0);
        plain(10'h001, 16'd2);
        step(1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'h000, 16'd3, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 200, exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
